// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM for the multicycle MIPS datapath. It decodes the opcode and
// walks through fetch / decode / execute / memory / writeback, one state per
// clock. The unified memory uses a ready handshake. A bounded wait counter
// sends the core to HALT if an access stalls for too long.
//
// Parameters
//   TIMEOUT    max cycles waiting for mem_ready in a memory state (1..255);
//              0 disables the timeout
//
// Ports
//   clk        core clock, rising edge
//   reset      asynchronous reset, active-high
//   op         instruction opcode instr[31:26], valid from DECODE onward
//   zero       ALU zero flag
//   mem_ready  memory completes the current access this cycle
//   mem_req    memory access request
//   memwrite   write strobe (meaningful only with mem_req)
//   iord       address select: 0 = PC, 1 = ALUOut
//   irwrite    instruction register load
//   pcen       PC load enable
//   pcsrc      PC source: 00 ALUResult, 01 ALUOut, 10 jump target
//   alusrca    ALU A: 0 = PC, 1 = register A
//   alusrcb    ALU B: 00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm << 2
//   aluop      ALU decoder code: 00 add, 01 sub, 10 use funct
//   regwrite   register file write enable
//   regdst     destination: 0 = rt, 1 = rd
//   memtoreg   writeback source: 0 = ALUOut, 1 = MDR
//   bad_op     one-cycle pulse in DECODE for an unsupported opcode
//   halted     sticky memory-timeout flag
//   state      current state, for debug
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       bad_op,
    output logic       halted,
    output logic [3:0] state
);

    localparam int unsigned CNT_W = 8;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_HALT    = 4'd15
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_halted;
    logic               w_mem_state;
    logic               w_timeout;

    // States that hold a memory access open until mem_ready
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                         (r_state == S_MEMWR);

    // Stall limit reached; a simultaneous mem_ready lets the access complete
    assign w_timeout = (TIMEOUT != 0) && w_mem_state && !mem_ready &&
                       (r_wait_cnt == TIMEOUT_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Memory wait counter: cleared on any state change, counts stalled cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_next != r_state) begin
            r_wait_cnt <= '0;
        end else if (w_mem_state && !mem_ready) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // Sticky halt flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else if (w_timeout) begin
            r_halted <= 1'b1;
        end
    end

    // Next state and Moore outputs (irwrite/pcen in FETCH follow mem_ready)
    always_comb begin
        w_next   = r_state;
        mem_req  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcen     = 1'b0;
        pcsrc    = PCSRC_ALU;
        alusrca  = 1'b0;
        alusrcb  = SRCB_B;
        aluop    = ALUOP_ADD;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        bad_op   = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = SRCB_FOUR;
                irwrite = mem_ready;
                pcen    = mem_ready;
                if (mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default: begin
                        w_next = S_FETCH;
                        bad_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                // op is stable through the instruction; only lw/sw reach here
                w_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                w_next   = S_FETCH;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                pcen    = zero;
                w_next  = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_JEX: begin
                pcsrc  = PCSRC_JUMP;
                pcen   = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        if (w_timeout) begin
            w_next = S_HALT;
        end
    end

    assign halted = r_halted;
    assign state  = r_state;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. Decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback steps, one state per clock. Drives the `aluop` code consumed by the ALU decoder and all datapath mux and enable signals. Supports a ready-handshaked unified memory, with a bounded wait timeout that halts the core.

Parameters:
TIMEOUT, 255, maximum cycles spent waiting for mem_ready in a memory state (1..255); 0 disables the timeout.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous reset, active-high
op  input  6  instruction opcode, instr[31:26], valid from DECODE onward
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
memwrite  output  1  write strobe, meaningful only with mem_req
iord  output  1  address select: 0 = PC, 1 = ALUOut
irwrite  output  1  instruction register load
pcen  output  1  PC load enable
pcsrc  output  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
alusrca  output  1  ALU A: 0 = PC, 1 = register A
alusrcb  output  2  ALU B: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
aluop  output  2  to ALU decoder: 00 = add, 01 = sub, 10 = use funct
regwrite  output  1  register file write enable
regdst  output  1  destination: 0 = rt, 1 = rd
memtoreg  output  1  writeback source: 0 = ALUOut, 1 = MDR
bad_op  output  1  one-cycle pulse in DECODE when the opcode is unsupported
halted  output  1  sticky: memory timeout occurred
state  output  4  current state, for debug

Behaviour:
- Opcodes:
  - lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
  - Any other opcode is illegal.
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, HALT 15.
- Reset:
  - Asynchronous; state becomes FETCH, wait counter 0, halted 0.
  - All outputs take their FETCH values combinationally with mem_ready = 0: mem_req=1, alusrcb=01, everything else 0.
- Transitions:
  - FETCH -> DECODE on mem_ready.
  - DECODE -> MEMADR (lw/sw), EXECUTE (R-type), BEQEX, ADDIEX, JEX by opcode. Illegal opcode -> FETCH with bad_op=1 for that cycle.
  - MEMADR -> MEMRD (lw) or MEMWR (sw).
  - MEMRD -> MEMWB on mem_ready.
  - MEMWR -> FETCH on mem_ready.
  - MEMWB, ALUWB, ADDIWB, BEQEX, JEX -> FETCH.
  - EXECUTE -> ALUWB; ADDIEX -> ADDIWB.
  - HALT -> HALT until reset.
- Outputs are Moore, except irwrite and pcen in FETCH, which are qualified by mem_ready. Unlisted outputs are 0.
  - FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=mem_ready, pcen=mem_ready.
  - DECODE: alusrca=0, alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: mem_req=1, iord=1.
  - MEMWB: regwrite=1, regdst=0, memtoreg=1.
  - MEMWR: mem_req=1, memwrite=1, iord=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regwrite=1, regdst=1.
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWB: regwrite=1, regdst=0.
  - JEX: pcsrc=10, pcen=1.
  - HALT: all 0, halted=1.
- Memory wait counter:
  - 8-bit counter, cleared on every state change.
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
- Timeout:
  - Applies when TIMEOUT != 0, the counter equals TIMEOUT-1 and mem_ready=0 in a memory state.
  - Next state is HALT and halted is set.
  - mem_ready=1 on that same cycle wins: the access completes normally.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Reset asserted mid-instruction aborts immediately to FETCH. No partial writeback occurs after reset deassertion.

Test Plan:
- Reset, then mem_ready=1 constantly, op=000000 -> states 0,1,6,7,0. aluop=10 in EXECUTE; regwrite=1, regdst=1 only in ALUWB; irwrite=pcen=1 in FETCH.
- lw (100011) with mem_ready held low 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0. mem_req=1, iord=1 throughout MEMRD; memtoreg=1, regwrite=1 in MEMWB.
- beq (000100): zero=1 -> pcen=1, pcsrc=01, aluop=01 in BEQEX. Repeat with zero=0 -> pcen=0. Next state FETCH in both cases.
- op=111111 -> DECODE asserts bad_op for exactly one cycle, then FETCH. No regwrite or memwrite at any point.
- TIMEOUT=4, mem_ready=0 in FETCH -> after 4 FETCH cycles state=15, halted=1, all controls 0. Stays HALT until reset; reset returns to FETCH with halted=0.
- Async reset pulsed mid-cycle during MEMWR -> state=0 and memwrite=0 before the next clock edge.
